piso_shift_tx: RTL and testbench
================================

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = serialise bit WIDTH-1 first, 0 = serialise bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port R, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port D, input, WIDTH bits: parallel word to transmit.
REQ-006 SHALL have port load_valid, input, 1 bit: D holds a word offered for transmission.
REQ-007 SHALL have port load_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port Q, output, 1 bit: serial data out.
REQ-009 SHALL have port Qb, output, 1 bit: complement of Q.
REQ-010 SHALL have port frame, output, 1 bit: Q carries a valid data bit this cycle.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL drive every output from registers only; no combinational path from any input to any output.
REQ-014 SHALL drive Qb as the exact complement of Q in every cycle, including during and after reset.
REQ-015 In IDLE: load_ready=1, frame=0, done=0, Q=0.
REQ-016 Acceptance SHALL occur on a rising edge where load_valid=1 and load_ready=1: capture D into the shift register, load bit counter with WIDTH-1, and go to SHIFT.
REQ-017 If load_valid=0 in IDLE, the FSM SHALL remain in IDLE with all outputs unchanged.
REQ-018 In SHIFT: load_ready=0, frame=1, and Q = current first-out bit (bit WIDTH-1 if MSB_FIRST=1, else bit 0).
REQ-019 The first data bit SHALL appear on Q in the first cycle after the acceptance edge (latency 1 cycle).
REQ-020 Each rising edge in SHIFT SHALL advance the shift register by one bit toward the output end and decrement the counter.
REQ-021 On the edge where the counter is 0, the FSM SHALL leave SHIFT for DONE; frame is therefore 1 for exactly WIDTH consecutive cycles.
REQ-022 In DONE: done=1, frame=0, Q=0, load_ready=0 for exactly one cycle; the FSM then returns unconditionally to IDLE.
REQ-023 The minimum word period SHALL be WIDTH+2 cycles, from acceptance edge to next acceptance edge.
REQ-024 While load_ready=0, the block SHALL ignore load_valid and D; D changes during SHIFT SHALL NOT alter transmitted bits.
REQ-025 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap below 0.

Reset
REQ-026 When R=1 at a rising edge, the next state SHALL be IDLE, with shift register=0, counter=0, Q=0, Qb=1, frame=0, done=0, load_ready=1.
REQ-027 R SHALL take priority over load_valid and over all FSM transitions.
REQ-028 R asserted during SHIFT or DONE SHALL abort the word, with no done pulse generated for it.
REQ-029 The first acceptance after reset deassertion SHALL be possible on the first rising edge with R=0.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, D=8'hA5, one-cycle load_valid pulse -> Q = 1,0,1,0,0,1,0,1 over 8 cycles with frame=1, then done=1 for one cycle, then load_ready=1.
REQ-031 MSB_FIRST=0, D=8'hA5 -> Q = 1,0,1,0,0,1,0,1 (LSB first); D=8'h01 -> Q = 1,0,0,0,0,0,0,0.
REQ-032 load_valid held high continuously with D=8'hFF, then 8'h00 -> back-to-back words at a 10-cycle period; no word lost or duplicated; Qb==~Q in every cycle.
REQ-033 D changed to 8'h00 in cycle 3 of SHIFT for word 8'hC3 -> transmitted bits still 1,1,0,0,0,0,1,1.
REQ-034 R=1 asserted in cycle 4 of SHIFT -> next cycle frame=0, Q=0, Qb=1, load_ready=1, no done pulse; a new word is accepted on the first edge with R=0.
REQ-035 WIDTH=2, D=2'b10 -> frame high for exactly 2 cycles, Q=1,0, then done pulse, period 4 cycles.

Source files
------------

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in serial-out transmitter with a valid/ready load
//               handshake, framed serial output and an end-of-word pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             Q,
    output logic             Qb,
    output logic             frame,
    output logic             done
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam int                 c_OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_frame;
    logic               r_done;
    logic               r_load_ready;
    logic [WIDTH-1:0]   w_shift_adv;

    // Zeros are shifted in, so the register drains to all-zero by the time
    // the word completes and Q naturally idles low.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (R) begin
            r_state      <= c_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_frame      <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (load_valid) begin
                        r_state      <= c_SHIFT;
                        r_shift      <= D;
                        r_cnt        <= c_CNT_LOAD;
                        r_frame      <= 1'b1;
                        r_load_ready <= 1'b0;
                    end
                end
                c_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_state <= c_DONE;
                        r_shift <= '0;
                        r_frame <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_shift <= w_shift_adv;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                c_DONE: begin
                    r_state      <= c_IDLE;
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_shift      <= '0;
                    r_cnt        <= '0;
                    r_frame      <= 1'b0;
                    r_done       <= 1'b0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign Q          = r_shift[c_OUT_IDX];
    assign Qb         = ~r_shift[c_OUT_IDX];
    assign frame      = r_frame;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_tx
// Description : Directed self-checking bench for piso_shift_tx (MSB-first,
//               LSB-first and 2-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       R;
    logic [7:0] d_a, d_b;
    logic [1:0] d_c;
    logic       lv_a, lv_b, lv_c;
    logic       lr_a, lr_b, lr_c;
    logic       q_a, q_b, q_c;
    logic       qb_a, qb_b, qb_c;
    logic       fr_a, fr_b, fr_c;
    logic       dn_a, dn_b, dn_c;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int start_prev;
    int start_cur;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .R(R), .D(d_a), .load_valid(lv_a), .load_ready(lr_a),
        .Q(q_a), .Qb(qb_a), .frame(fr_a), .done(dn_a)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .R(R), .D(d_b), .load_valid(lv_b), .load_ready(lr_b),
        .Q(q_b), .Qb(qb_b), .frame(fr_b), .done(dn_b)
    );

    piso_shift_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) u_dut_c (
        .clk(clk), .R(R), .D(d_c), .load_valid(lv_c), .load_ready(lr_c),
        .Q(q_c), .Qb(qb_c), .frame(fr_c), .done(dn_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called in the first SHIFT cycle; returns in the IDLE cycle after DONE.
    task automatic shift_a(input logic [7:0] word, input int zero_d_at);
        logic eb;
        start_cur = cyc;
        for (int i = 0; i < 8; i++) begin
            if (i == zero_d_at) d_a = 8'h00;
            eb = word[7-i];
            check("a_q", q_a, eb);
            check("a_qb", qb_a, !eb);
            check("a_frame", fr_a, 1);
            check("a_ready", lr_a, 0);
            check("a_done", dn_a, 0);
            tick();
        end
        check("a_done_pulse", dn_a, 1);
        check("a_done_frame", fr_a, 0);
        check("a_done_q", q_a, 0);
        check("a_done_qb", qb_a, 1);
        check("a_done_ready", lr_a, 0);
        tick();
        check("a_idle_ready", lr_a, 1);
        check("a_idle_done", dn_a, 0);
        check("a_idle_frame", fr_a, 0);
        check("a_idle_q", q_a, 0);
    endtask

    task automatic shift_b(input logic [7:0] word);
        logic eb;
        for (int i = 0; i < 8; i++) begin
            eb = word[i];
            check("b_q", q_b, eb);
            check("b_qb", qb_b, !eb);
            check("b_frame", fr_b, 1);
            tick();
        end
        check("b_done_pulse", dn_b, 1);
        check("b_done_frame", fr_b, 0);
        tick();
        check("b_idle_ready", lr_b, 1);
    endtask

    initial begin
        R = 1'b1;
        d_a = 8'h00; d_b = 8'h00; d_c = 2'b00;
        lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
        tick();
        tick();
        check("rst_ready", lr_a, 1);
        check("rst_frame", fr_a, 0);
        check("rst_done", dn_a, 0);
        check("rst_q", q_a, 0);
        check("rst_qb", qb_a, 1);
        check("rst_b_ready", lr_b, 1);
        check("rst_c_ready", lr_c, 1);
        R = 1'b0;

        // IDLE holds with no request
        d_a = 8'h5A;
        tick();
        tick();
        check("idle_hold_ready", lr_a, 1);
        check("idle_hold_frame", fr_a, 0);
        check("idle_hold_q", q_a, 0);

        // A5 MSB first, single-cycle valid pulse
        d_a = 8'hA5; lv_a = 1'b1;
        tick();
        lv_a = 1'b0;
        shift_a(8'hA5, -1);

        // D disturbed during SHIFT must not affect the word in flight
        d_a = 8'hC3; lv_a = 1'b1;
        tick();
        lv_a = 1'b0;
        shift_a(8'hC3, 2);

        // Back-to-back with valid held high: FF then 00, 10-cycle period
        d_a = 8'hFF; lv_a = 1'b1;
        tick();
        shift_a(8'hFF, 3);
        start_prev = start_cur;
        tick();
        shift_a(8'h00, -1);
        check("b2b_period", start_cur - start_prev, 10);
        lv_a = 1'b0;
        tick();
        check("b2b_no_extra", fr_a, 0);

        // Reset in SHIFT cycle 4 aborts the word without a done pulse
        d_a = 8'hA5; lv_a = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("abort_pre_frame", fr_a, 1);
        R = 1'b1;
        tick();
        check("abort_frame", fr_a, 0);
        check("abort_q", q_a, 0);
        check("abort_qb", qb_a, 1);
        check("abort_ready", lr_a, 1);
        check("abort_done", dn_a, 0);
        R = 1'b0; d_a = 8'h3C; lv_a = 1'b1;
        tick();
        lv_a = 1'b0;
        check("post_rst_accept", fr_a, 1);
        shift_a(8'h3C, -1);

        // LSB-first instance
        d_b = 8'hA5; lv_b = 1'b1;
        tick();
        lv_b = 1'b0;
        shift_b(8'hA5);
        d_b = 8'h01; lv_b = 1'b1;
        tick();
        lv_b = 1'b0;
        shift_b(8'h01);

        // WIDTH=2, valid held: frame 1,1 / done / idle, repeating every 4
        d_c = 2'b10; lv_c = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check("c_frame", fr_c, (k % 4) < 2);
            check("c_q", q_c, (k % 4) == 0);
            check("c_qb", qb_c, (k % 4) != 0);
            check("c_done", dn_c, (k % 4) == 2);
            check("c_ready", lr_c, (k % 4) == 3);
            tick();
        end
        lv_c = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
